// File: rtl/reg_file_8x8.sv
// 8x8 general-purpose register file: two asynchronous read ports, one synchronous
// write port, and an enable-captured copy of R0 driving reg0_out.
module reg_file_8x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clka,
    input  logic                  reset_in,
    input  logic                  pc_latch_clk,
    input  logic                  we_reg_in,
    input  logic [ADDR_WIDTH-1:0] sr1_in,
    input  logic [ADDR_WIDTH-1:0] sr2_in,
    input  logic [ADDR_WIDTH-1:0] rd_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] sr1_out,
    output logic [DATA_WIDTH-1:0] sr2_out,
    output logic [DATA_WIDTH-1:0] reg0_out
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_l0;

    // Register storage: reset clears all, otherwise single write port.
    always_ff @(posedge clka) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we_reg_in) begin
            r_regs[rd_in] <= data_in;
        end
    end

    // R0 capture: samples R0 as it stood before this edge, so a same-edge write is not seen.
    always_ff @(posedge clka) begin
        if (reset_in) begin
            r_l0 <= '0;
        end else if (pc_latch_clk) begin
            r_l0 <= r_regs[0];
        end
    end

    assign sr1_out  = r_regs[sr1_in];
    assign sr2_out  = r_regs[sr2_in];
    assign reg0_out = r_l0;

endmodule

// File: tb/tb_reg_file_8x8.sv
// Self-checking bench for reg_file_8x8: directed plan scenarios plus randomized
// traffic checked against an array-based reference model.
module tb_reg_file_8x8;

    logic       clka = 1'b0;
    logic       reset_in;
    logic       pc_latch_clk;
    logic       we_reg_in;
    logic [2:0] sr1_in;
    logic [2:0] sr2_in;
    logic [2:0] rd_in;
    logic [7:0] data_in;
    logic [7:0] sr1_out;
    logic [7:0] sr2_out;
    logic [7:0] reg0_out;

    logic [7:0] m_r [8];
    logic [7:0] m_l0;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clka = ~clka;

    reg_file_8x8 dut (
        .clka        (clka),
        .reset_in    (reset_in),
        .pc_latch_clk(pc_latch_clk),
        .we_reg_in   (we_reg_in),
        .sr1_in      (sr1_in),
        .sr2_in      (sr2_in),
        .rd_in       (rd_in),
        .data_in     (data_in),
        .sr1_out     (sr1_out),
        .sr2_out     (sr2_out),
        .reg0_out    (reg0_out)
    );

    task automatic drive(input logic rst, input logic we, input logic pcl,
                         input logic [2:0] rd, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [7:0] d);
        reset_in     = rst;
        we_reg_in    = we;
        pc_latch_clk = pcl;
        rd_in        = rd;
        sr1_in       = s1;
        sr2_in       = s2;
        data_in      = d;
    endtask

    // One rising edge; the model applies the edge's effect using pre-edge R0 for the latch.
    task automatic tick();
        logic [7:0] old_r0;
        @(posedge clka);
        old_r0 = m_r[0];
        if (reset_in) begin
            for (int i = 0; i < 8; i++) m_r[i] = 8'd0;
            m_l0 = 8'd0;
        end else begin
            if (pc_latch_clk) m_l0 = old_r0;
            if (we_reg_in) m_r[rd_in] = data_in;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
        tick();
        n_tests++; if (sr1_out !== 8'd0) begin n_fail++; $display("FAIL reset_sr1 got %h want %h", sr1_out, 8'd0); end
        n_tests++; if (sr2_out !== 8'd0) begin n_fail++; $display("FAIL reset_sr2 got %h want %h", sr2_out, 8'd0); end
        n_tests++; if (reg0_out !== 8'd0) begin n_fail++; $display("FAIL reset_reg0 got %h want %h", reg0_out, 8'd0); end
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b1, 1'b0, 3'd1, 3'd1, 3'd2, 8'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 3'd2, 3'd1, 3'd2, 8'd2);
        tick();
        n_tests++; if (sr1_out !== 8'd1) begin n_fail++; $display("FAIL wr_sr1 got %h want %h", sr1_out, 8'd1); end
        n_tests++; if (sr2_out !== 8'd2) begin n_fail++; $display("FAIL wr_sr2 got %h want %h", sr2_out, 8'd2); end
    endtask

    task automatic test_pc_latch();
        drive(1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 8'd8);
        tick();
        n_tests++; if (reg0_out !== 8'd0) begin n_fail++; $display("FAIL latch_hold got %h want %h", reg0_out, 8'd0); end
        drive(1'b0, 1'b1, 1'b1, 3'd3, 3'd3, 3'd2, 8'd3);
        tick();
        n_tests++; if (reg0_out !== 8'd8) begin n_fail++; $display("FAIL latch_cap got %h want %h", reg0_out, 8'd8); end
        n_tests++; if (sr1_out !== 8'd3) begin n_fail++; $display("FAIL latch_sr1 got %h want %h", sr1_out, 8'd3); end
        // Same-edge write to R0 must not reach the latch until the following latching edge.
        drive(1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd2, 8'h55);
        tick();
        n_tests++; if (reg0_out !== 8'd8) begin n_fail++; $display("FAIL latch_old got %h want %h", reg0_out, 8'd8); end
        n_tests++; if (sr1_out !== 8'h55) begin n_fail++; $display("FAIL r0_write got %h want %h", sr1_out, 8'h55); end
        drive(1'b0, 1'b0, 1'b1, 3'd0, 3'd3, 3'd2, 8'd0);
        tick();
        n_tests++; if (reg0_out !== 8'h55) begin n_fail++; $display("FAIL latch_new got %h want %h", reg0_out, 8'h55); end
    endtask

    task automatic test_write_disable();
        drive(1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 3'd2, 8'hEE);
        tick();
        n_tests++; if (sr1_out !== 8'd3) begin n_fail++; $display("FAIL we_off got %h want %h", sr1_out, 8'd3); end
        drive(1'b0, 1'b1, 1'b0, 3'd1, 3'd1, 3'd2, 8'd10);
        tick();
        n_tests++; if (sr1_out !== 8'd10) begin n_fail++; $display("FAIL wr10_sr1 got %h want %h", sr1_out, 8'd10); end
        n_tests++; if (sr2_out !== 8'd2) begin n_fail++; $display("FAIL wr10_sr2 got %h want %h", sr2_out, 8'd2); end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 1'b1, 1'b1, 3'd3, 3'd1, 3'd2, 8'd3);
        tick();
        n_tests++; if (reg0_out !== 8'd0) begin n_fail++; $display("FAIL rstp_reg0 got %h want %h", reg0_out, 8'd0); end
        n_tests++; if (sr1_out !== 8'd0) begin n_fail++; $display("FAIL rstp_sr1 got %h want %h", sr1_out, 8'd0); end
        n_tests++; if (sr2_out !== 8'd0) begin n_fail++; $display("FAIL rstp_sr2 got %h want %h", sr2_out, 8'd0); end
        for (int i = 0; i < 8; i++) begin
            sr1_in = 3'(i);
            #1;
            n_tests++;
            if (sr1_out !== 8'd0) begin n_fail++; $display("FAIL rstp_r%0d got %h want %h", i, sr1_out, 8'd0); end
        end
    endtask

    task automatic test_after_reset();
        drive(1'b0, 1'b1, 1'b1, 3'd3, 3'd1, 3'd2, 8'd3);
        tick();
        n_tests++; if (reg0_out !== 8'd0) begin n_fail++; $display("FAIL ar_reg0 got %h want %h", reg0_out, 8'd0); end
        n_tests++; if (sr1_out !== 8'd0) begin n_fail++; $display("FAIL ar_sr1 got %h want %h", sr1_out, 8'd0); end
        n_tests++; if (sr2_out !== 8'd0) begin n_fail++; $display("FAIL ar_sr2 got %h want %h", sr2_out, 8'd0); end
        sr1_in = 3'd3;
        #1;
        n_tests++; if (sr1_out !== 8'd3) begin n_fail++; $display("FAIL ar_r3 got %h want %h", sr1_out, 8'd3); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
                  3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
            #1;
            // Before the edge the read ports must still show stored data, never data_in.
            n_tests++;
            if (sr1_out !== m_r[sr1_in] || sr2_out !== m_r[sr2_in]) begin
                n_fail++;
                $display("FAIL rnd_pre it=%0d got %h/%h want %h/%h", n, sr1_out, sr2_out, m_r[sr1_in], m_r[sr2_in]);
            end
            tick();
            n_tests++;
            if (sr1_out !== m_r[sr1_in]) begin n_fail++; $display("FAIL rnd_sr1 it=%0d got %h want %h", n, sr1_out, m_r[sr1_in]); end
            n_tests++;
            if (sr2_out !== m_r[sr2_in]) begin n_fail++; $display("FAIL rnd_sr2 it=%0d got %h want %h", n, sr2_out, m_r[sr2_in]); end
            n_tests++;
            if (reg0_out !== m_l0) begin n_fail++; $display("FAIL rnd_reg0 it=%0d got %h want %h", n, reg0_out, m_l0); end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
        for (int i = 0; i < 8; i++) m_r[i] = 8'd0;
        m_l0 = 8'd0;
        @(negedge clka);
        test_reset();
        test_write_read();
        test_pc_latch();
        test_write_disable();
        test_reset_priority();
        test_after_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_8x8.md
Name: reg_file_8x8

Overview:
- General-purpose register file for the 8-bit microprocessor datapath: 8 registers × 8 bits.
- Two combinational read ports (sr1, sr2) feed the ALU.
- One synchronous write port takes the writeback result.
- A latched copy of R0 drives reg0_out, which the program-counter/output logic consumes; it updates only when pc_latch_clk is asserted.

Parameters:
DATA_WIDTH, 8, width of each register and of all data ports
ADDR_WIDTH, 3, register address width; register count = 2**ADDR_WIDTH (8)

Ports:
clka  input  1  single system clock; all state updates on its rising edge
reset_in  input  1  synchronous active-high reset
pc_latch_clk  input  1  synchronous enable: capture R0 into the reg0_out latch
we_reg_in  input  1  write enable for the write port
sr1_in  input  ADDR_WIDTH  read port 1 register select
sr2_in  input  ADDR_WIDTH  read port 2 register select
rd_in  input  ADDR_WIDTH  write destination register select
data_in  input  DATA_WIDTH  write data
sr1_out  output  DATA_WIDTH  contents of register sr1_in
sr2_out  output  DATA_WIDTH  contents of register sr2_in
reg0_out  output  DATA_WIDTH  latched copy of R0

Behaviour:
- One clock (clka); reset is synchronous and active-high (reset_in). No other clock inputs.
- Storage: R0..R7, each DATA_WIDTH bits, plus one DATA_WIDTH-bit latch, L0, that drives reg0_out.
- Reset: on a rising clka with reset_in=1, R0..R7 and L0 are cleared to 0.
  - Reset has priority: write and pc latch are ignored that edge.
  - sr1_out, sr2_out and reg0_out read 0 after the reset edge.
- Write: on a rising clka with reset_in=0 and we_reg_in=1, R[rd_in] <= data_in.
  - Every register, R0 included, is writable; there is no hardwired zero.
  - With we_reg_in=0, no register changes.
- Read: sr1_out = R[sr1_in] and sr2_out = R[sr2_in], purely combinational (asynchronous).
  - Both ports may select the same register.
  - A register written at an edge appears on the read ports immediately after that edge. No same-cycle bypass of data_in before the edge.
- PC latch: on a rising clka with reset_in=0 and pc_latch_clk=1, L0 <= R0.
  - The value captured is R0's value before that edge.
  - A simultaneous write to R0 is visible in L0 only at the next latching edge.
  - With pc_latch_clk=0, L0 holds.
- Writing R0 without pc_latch_clk does not change reg0_out.
- Latency:
  - Write to read-out: 0 cycles after the edge.
  - R0 to reg0_out: one latching edge.
- Out-of-range addresses are impossible: ADDR_WIDTH fully decodes 2**ADDR_WIDTH registers.
- No X propagation after the first reset. Power-up contents are undefined until reset.

Test Plan:
1. Reset with we_reg_in=0, all selects 0 → sr1_out=sr2_out=reg0_out=0.
2. Write data_in=1 to rd_in=1, then data_in=2 to rd_in=2, with sr1_in=1 and sr2_in=2 → after the edges sr1_out=1, sr2_out=2.
3. Write data_in=8 to rd_in=0 with pc_latch_clk=0 → reg0_out stays 0. Next edge: pc_latch_clk=1, write 3 to R3, sr1_in=3 → reg0_out=8, sr1_out=3.
4. we_reg_in=0 with data_in=3, rd_in=3 → R3 unchanged (3). Then write 10 to R1, sr1_in=1 → sr1_out=10, sr2_out=2.
5. reset_in=1 together with we_reg_in=1 (write 3 to R3) and pc_latch_clk=1 → all registers 0, reg0_out=0, sr1_out(R1)=0, sr2_out(R2)=0, R3=0.
6. After reset, pc_latch_clk=1 with a write of 3 to R3 → reg0_out=0 (R0 is 0), R3=3 on the next edge, R1 and R2 read 0.
